// File: rtl/s32x_sdr_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : s32x_sdr_bridge                                                  |
// | Brief   : SH-2 SDRAM port to board controller bridge with a 2-entry posted |
// |           write queue and a registered single-word read path.              |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module s32x_sdr_bridge #(
  parameter int QDEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [16:0] SDR_A,
  input  logic [15:0] SDR_DO,
  input  logic        SDR_CS,
  input  logic [1:0]  SDR_WE,
  input  logic        SDR_RD,
  output logic [15:0] SDR_DI,
  output logic        SDR_WAIT,
  output logic [16:0] MEM_A,
  output logic [15:0] MEM_DO,
  output logic [1:0]  MEM_BE,
  output logic        MEM_WE,
  output logic        MEM_REQ,
  input  logic [15:0] MEM_DI,
  input  logic        MEM_ACK
);

  // Only a depth of 2 is supported: 1-bit pointers wrap 1->0.
  localparam logic [1:0] c_QDEPTH = 2'(QDEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t      r_state;
  logic [16:0] r_qa  [0:1];
  logic [15:0] r_qd  [0:1];
  logic [1:0]  r_qbe [0:1];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;
  logic        r_served;
  logic [15:0] r_rdata;
  logic [16:0] r_mem_a;
  logic [15:0] r_mem_do;
  logic [1:0]  r_mem_be;
  logic        r_mem_we;
  logic        r_mem_req;

  logic w_acc;
  logic w_wr;
  logic w_rd;
  logic w_space;
  logic w_push;
  logic w_pop;

  assign w_acc   = SDR_CS & (SDR_RD | (|SDR_WE));
  assign w_wr    = w_acc & (|SDR_WE);
  assign w_rd    = w_acc & ~(|SDR_WE);
  assign w_space = (r_count < c_QDEPTH);
  assign w_push  = w_wr & ~r_served & w_space;
  assign w_pop   = (r_state == S_WR) & MEM_ACK;

  assign SDR_WAIT = w_acc & ~r_served & ~(w_wr & w_space);
  assign SDR_DI   = r_rdata;
  assign MEM_A    = r_mem_a;
  assign MEM_DO   = r_mem_do;
  assign MEM_BE   = r_mem_be;
  assign MEM_WE   = r_mem_we;
  assign MEM_REQ  = r_mem_req;

  // Queue payload needs no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_qa[r_wptr]  <= SDR_A;
      r_qd[r_wptr]  <= SDR_DO;
      r_qbe[r_wptr] <= SDR_WE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
      r_served  <= 1'b0;
      r_rdata   <= 16'h0000;
      r_mem_a   <= 17'h00000;
      r_mem_do  <= 16'h0000;
      r_mem_be  <= 2'b00;
      r_mem_we  <= 1'b0;
      r_mem_req <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      if (!w_acc)
        r_served <= 1'b0;
      else if (w_push || ((r_state == S_RD) && MEM_ACK))
        r_served <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_count != 2'd0) begin
            r_mem_a   <= r_qa[r_rptr];
            r_mem_do  <= r_qd[r_rptr];
            r_mem_be  <= r_qbe[r_rptr];
            r_mem_we  <= 1'b1;
            r_mem_req <= 1'b1;
            r_state   <= S_WR;
          end else if (w_push) begin
            // Empty queue: present the incoming write straight away; it still
            // occupies the head slot and is popped on its ACK.
            r_mem_a   <= SDR_A;
            r_mem_do  <= SDR_DO;
            r_mem_be  <= SDR_WE;
            r_mem_we  <= 1'b1;
            r_mem_req <= 1'b1;
            r_state   <= S_WR;
          end else if (w_rd && !r_served) begin
            r_mem_a   <= SDR_A;
            r_mem_be  <= 2'b11;
            r_mem_we  <= 1'b0;
            r_mem_req <= 1'b1;
            r_state   <= S_RD;
          end
        end
        S_WR: begin
          if (MEM_ACK) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_RD: begin
          if (MEM_ACK) begin
            r_rdata   <= MEM_DI;
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_s32x_sdr_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_s32x_sdr_bridge                                               |
// | Brief   : Directed bench for s32x_sdr_bridge with a latency-programmable   |
// |           SDRAM controller model.                                          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_s32x_sdr_bridge;

  logic        CLK = 1'b0;
  logic        RST;
  logic [16:0] SDR_A;
  logic [15:0] SDR_DO;
  logic        SDR_CS;
  logic [1:0]  SDR_WE;
  logic        SDR_RD;
  logic [15:0] SDR_DI;
  logic        SDR_WAIT;
  logic [16:0] MEM_A;
  logic [15:0] MEM_DO;
  logic [1:0]  MEM_BE;
  logic        MEM_WE;
  logic        MEM_REQ;
  logic [15:0] MEM_DI;
  logic        MEM_ACK;

  logic        ack_m = 1'b0;
  logic        ack_f = 1'b0;
  logic [15:0] di_m  = 16'h0000;
  logic [15:0] di_f  = 16'h0000;

  assign MEM_ACK = ack_m | ack_f;
  assign MEM_DI  = ack_f ? di_f : di_m;

  s32x_sdr_bridge #(.QDEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .SDR_A(SDR_A), .SDR_DO(SDR_DO), .SDR_CS(SDR_CS), .SDR_WE(SDR_WE),
    .SDR_RD(SDR_RD), .SDR_DI(SDR_DI), .SDR_WAIT(SDR_WAIT),
    .MEM_A(MEM_A), .MEM_DO(MEM_DO), .MEM_BE(MEM_BE), .MEM_WE(MEM_WE),
    .MEM_REQ(MEM_REQ), .MEM_DI(MEM_DI), .MEM_ACK(MEM_ACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd;
    logic [16:0] a;
    logic [15:0] d;
    logic [1:0]  we;
    int          lat;
    int          stall;
    logic [15:0] di;
  } vec_t;

  typedef struct {
    logic [16:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } wlog_t;

  vec_t        tv [9];
  vec_t        qv [3];
  wlog_t       wlog [$];
  logic [15:0] mem [logic [16:0]];
  logic [15:0] cur;

  int   n_cmp = 0;
  int   n_fail = 0;
  bit   model_on = 1'b0;
  int   lat = 0;
  int   wcnt = 0;
  int   n_req = 0;
  logic prev_req = 1'b0;
  int   st;
  int   n0;
  int   r0;

  function automatic logic [15:0] rdmem(input logic [16:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  // Controller model: ACK after 'lat' cycles of REQ, applies byte-enabled writes.
  always @(negedge CLK) begin
    if (MEM_REQ && !prev_req) n_req++;
    prev_req = MEM_REQ;
    if (!model_on) begin
      ack_m = 1'b0;
      wcnt  = 0;
    end else if (ack_m) begin
      ack_m = 1'b0;
      wcnt  = 0;
    end else if (MEM_REQ) begin
      if (wcnt >= lat) begin
        ack_m = 1'b1;
        if (MEM_WE) begin
          cur = rdmem(MEM_A);
          if (MEM_BE[0]) cur[7:0]  = MEM_DO[7:0];
          if (MEM_BE[1]) cur[15:8] = MEM_DO[15:8];
          mem[MEM_A] = cur;
          wlog.push_back('{MEM_A, MEM_DO, MEM_BE});
        end else begin
          di_m = rdmem(MEM_A);
        end
      end else begin
        wcnt++;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic rd, input logic [16:0] a, input logic [15:0] d,
                     input logic [1:0] we, output int stall);
    @(negedge CLK);
    SDR_CS = 1'b1; SDR_RD = rd; SDR_A = a; SDR_DO = d; SDR_WE = we;
    stall = 0;
    #1;
    while (SDR_WAIT === 1'b1 && stall < 200) begin
      @(negedge CLK);
      #1;
      stall++;
    end
    @(posedge CLK);
  endtask

  task automatic rel();
    @(negedge CLK);
    SDR_CS = 1'b0; SDR_RD = 1'b0; SDR_WE = 2'b00;
    #1;
  endtask

  task automatic drain();
    int q = 0;
    int t = 0;
    while (q < 3 && t < 200) begin
      @(negedge CLK);
      #1;
      q = MEM_REQ ? 0 : q + 1;
      t++;
    end
    if (t >= 200) chk("drain_timeout", 64'(MEM_REQ), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; SDR_CS = 1'b0; SDR_RD = 1'b0; SDR_WE = 2'b00;
    SDR_A = '0; SDR_DO = '0;
    mem[17'h1ABCD] = 16'hA5A5;

    //               rd    addr       data      we     lat stall di
    tv[0] = '{1'b0, 17'h00010, 16'hBEEF, 2'b11, 2, 0, 16'h0000};
    tv[1] = '{1'b0, 17'h00020, 16'h1111, 2'b01, 0, 0, 16'h0000};
    tv[2] = '{1'b1, 17'h00010, 16'h0000, 2'b00, 0, 2, 16'hBEEF};
    tv[3] = '{1'b1, 17'h00020, 16'h0000, 2'b00, 3, 5, 16'h0011};
    tv[4] = '{1'b0, 17'h00020, 16'hAB00, 2'b10, 1, 0, 16'h0000};
    tv[5] = '{1'b1, 17'h00020, 16'h0000, 2'b00, 1, 3, 16'hAB11};
    tv[6] = '{1'b1, 17'h1ABCD, 16'h0000, 2'b00, 0, 2, 16'hA5A5};
    tv[7] = '{1'b0, 17'h1FFFF, 16'hFFFF, 2'b11, 0, 0, 16'h0000};
    tv[8] = '{1'b1, 17'h1FFFF, 16'h0000, 2'b00, 5, 7, 16'hFFFF};

    qv[0] = '{1'b0, 17'h00100, 16'h0A0A, 2'b01, 4, 0, 16'h0000};
    qv[1] = '{1'b0, 17'h00101, 16'h0B0B, 2'b10, 4, 0, 16'h0000};
    qv[2] = '{1'b0, 17'h00102, 16'h0C0C, 2'b11, 4, 2, 16'h0000};

    // Reset values
    repeat (2) @(negedge CLK);
    SDR_CS = 1'b1; SDR_RD = 1'b1;
    #1;
    chk("rst_wait",  64'(SDR_WAIT), 64'(1));
    chk("rst_req",   64'(MEM_REQ),  64'(0));
    chk("rst_we",    64'(MEM_WE),   64'(0));
    chk("rst_a",     64'(MEM_A),    64'(0));
    chk("rst_do",    64'(MEM_DO),   64'(0));
    chk("rst_be",    64'(MEM_BE),   64'(0));
    chk("rst_di",    64'(SDR_DI),   64'(0));
    @(negedge CLK);
    SDR_CS = 1'b0; SDR_RD = 1'b0; RST = 1'b0;
    #1;
    model_on = 1'b1;

    // Table-driven single accesses with the queue drained between them
    for (int i = 0; i < 9; i++) begin
      lat = tv[i].lat;
      bus(tv[i].rd, tv[i].a, tv[i].d, tv[i].we, st);
      rel();
      chk($sformatf("v%0d_stall", i), 64'(st), 64'(tv[i].stall));
      if (!tv[i].rd) begin
        chk($sformatf("v%0d_memreq", i), 64'({MEM_REQ, MEM_WE, MEM_BE, MEM_A, MEM_DO}),
            64'({1'b1, 1'b1, tv[i].we, tv[i].a, tv[i].d}));
      end else begin
        @(negedge CLK);
        #1;
        chk($sformatf("v%0d_di_held", i), 64'(SDR_DI), 64'(tv[i].di));
      end
      drain();
    end

    // Queue full with ACK latency 4
    n0 = wlog.size();
    for (int i = 0; i < 3; i++) begin
      lat = qv[i].lat;
      bus(1'b0, qv[i].a, qv[i].d, qv[i].we, st);
      rel();
      chk($sformatf("qf%0d_stall", i), 64'(st), 64'(qv[i].stall));
    end
    drain();
    chk("qf_count", 64'(wlog.size() - n0), 64'(3));
    if (wlog.size() >= n0 + 3) begin
      for (int i = 0; i < 3; i++)
        chk($sformatf("qf%0d_order", i), 64'({wlog[n0+i].a, wlog[n0+i].d, wlog[n0+i].be}),
            64'({qv[i].a, qv[i].d, qv[i].we}));
    end

    // Read after write to the same address: no forwarding, waits for drain
    lat = 2;
    bus(1'b0, 17'h1F000, 16'h1234, 2'b11, st);
    rel();
    chk("raw_wr_stall", 64'(st), 64'(0));
    bus(1'b1, 17'h1F000, 16'h0000, 2'b00, st);
    rel();
    chk("raw_rd_stall", 64'(st), 64'(6));
    chk("raw_di",       64'(SDR_DI), 64'(16'h1234));
    drain();

    // Held strobe: one request per access
    lat = 0;
    r0 = n_req;
    @(negedge CLK);
    SDR_CS = 1'b1; SDR_RD = 1'b1; SDR_A = 17'h00010; SDR_WE = 2'b00;
    repeat (12) @(negedge CLK);
    #1;
    chk("held_wait", 64'(SDR_WAIT), 64'(0));
    chk("held_req1", 64'(n_req - r0), 64'(1));
    chk("held_di",   64'(SDR_DI), 64'(16'hBEEF));
    @(negedge CLK);
    SDR_CS = 1'b0; SDR_RD = 1'b0;
    @(negedge CLK);
    SDR_CS = 1'b1; SDR_RD = 1'b1;
    repeat (6) @(negedge CLK);
    #1;
    chk("held_req2", 64'(n_req - r0), 64'(2));
    rel();
    drain();

    // Reset mid-transaction with queued writes and stray ACKs
    model_on = 1'b0;
    n0 = wlog.size();
    @(negedge CLK);
    SDR_CS = 1'b1; SDR_RD = 1'b1; SDR_A = 17'h00005; SDR_WE = 2'b00;
    repeat (2) @(negedge CLK);
    #1;
    chk("mid_rd_req", 64'({MEM_REQ, MEM_WE, MEM_BE, MEM_A}), 64'({1'b1, 1'b0, 2'b11, 17'h00005}));
    rel();
    bus(1'b0, 17'h00200, 16'h5555, 2'b11, st);
    rel();
    chk("mid_wr0_stall", 64'(st), 64'(0));
    bus(1'b0, 17'h00201, 16'h6666, 2'b11, st);
    rel();
    chk("mid_wr1_stall", 64'(st), 64'(0));
    @(negedge CLK);
    RST = 1'b1; ack_f = 1'b1; di_f = 16'hFFFF;
    @(negedge CLK);
    ack_f = 1'b0;
    #1;
    chk("mid_req_drop", 64'(MEM_REQ), 64'(0));
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    ack_f = 1'b1; di_f = 16'hDEAD;
    @(negedge CLK);
    ack_f = 1'b0;
    #1;
    chk("mid_di_zero", 64'(SDR_DI), 64'(0));
    chk("mid_req_idle", 64'(MEM_REQ), 64'(0));
    r0 = n_req;
    model_on = 1'b1;
    repeat (10) @(negedge CLK);
    #1;
    chk("mid_q_dropped", 64'(wlog.size() - n0), 64'(0));
    chk("mid_no_req",    64'(n_req - r0), 64'(0));
    lat = 0;
    bus(1'b1, 17'h1ABCD, 16'h0000, 2'b00, st);
    rel();
    chk("post_rst_stall", 64'(st), 64'(2));
    chk("post_rst_di",    64'(SDR_DI), 64'(16'hA5A5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
